// File: rtl/hs_arb_pkg.sv
// Shared types for the hiscore / CPU work-RAM arbiter.
package hs_arb_pkg;

    localparam int unsigned GUARD_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_ARM   = 2'd1,
        ST_HS    = 2'd2,
        ST_GUARD = 2'd3
    } hs_arb_state_t;

endpackage

// File: rtl/hs_ram_arbiter.sv
// Hands the work-RAM port from the CPU to the hiscore engine while the CPU is paused.
// Optional HS_ARB_VBLANK_ONLY_EN: hiscore ownership is additionally limited to vblank.
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int unsigned AW    = 11,
    parameter int unsigned DW    = 8,
    parameter int unsigned GUARD = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          paused,
    input  logic          vblank,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write_enable,
    input  logic          hs_read_intent,
    input  logic          hs_write_intent,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_grant,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int unsigned CW = GUARD_CNT_W;

    hs_arb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cpu_cap_q;
    logic          intent;
    logic          grant_ok;

    assign intent = hs_read_intent | hs_write_intent;

`ifdef HS_ARB_VBLANK_ONLY_EN
    assign grant_ok = paused & vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign grant_ok      = paused;
`endif

    // Next state, guard countdown and the RAM port mux.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
        cpu_dout = cpu_cap_q;
        case (state_q)
            ST_CPU: begin
                ram_we   = cpu_we;
                cpu_dout = ram_dout;
                if (intent) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!intent)       state_d = ST_CPU;
                else if (grant_ok) state_d = ST_HS;
            end
            ST_HS: begin
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                ram_we   = hs_write_enable & paused;
                if (!intent || !grant_ok) begin
                    state_d = ST_GUARD;
                    cnt_d   = CW'(GUARD - 1);
                end
            end
            ST_GUARD: begin
                // Address stays on the hiscore side so the RAM sees no CPU glitch.
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                if (cnt_q == '0) state_d = ST_CPU;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = ST_CPU;
        endcase
    end

    // State register plus registered grant and read-data captures.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CPU;
            cnt_q       <= '0;
            hs_grant    <= 1'b0;
            hs_data_out <= '0;
            cpu_cap_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hs_grant <= (state_d == ST_HS);
            if (state_q == ST_HS)  hs_data_out <= ram_dout;
            if (state_q == ST_CPU) cpu_cap_q   <= ram_dout;
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: vector table, directed corner sequences, random run vs. model.
module tb_hs_ram_arbiter;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;
    localparam int unsigned GUARD = 2;
    localparam int M_CPU = 0, M_ARM = 1, M_HS = 2, M_GRD = 3;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          paused, vblank;
    logic [AW-1:0] cpu_addr, hs_address, ram_addr;
    logic          cpu_we, hs_write_enable, hs_read_intent, hs_write_intent;
    logic [DW-1:0] cpu_din, cpu_dout, hs_data_in, hs_data_out, ram_din, ram_dout;
    logic          hs_grant, ram_we;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] mem    [0:2047];
    logic [DW-1:0] shadow [0:2047];

    always #5 clk_sys = ~clk_sys;

    // Synchronous work RAM, read-before-write.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    hs_ram_arbiter #(.AW(AW), .DW(DW), .GUARD(GUARD)) dut (
        .clk_sys(clk_sys), .reset(reset), .paused(paused), .vblank(vblank),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write_enable(hs_write_enable),
        .hs_read_intent(hs_read_intent), .hs_write_intent(hs_write_intent),
        .hs_data_out(hs_data_out), .hs_grant(hs_grant),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    typedef struct {
        logic rint, wint, p, hwe, cwe;
        logic eg, ewe, ehs;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        paused = 1'b0; vblank = 1'b1;
        cpu_addr = '0; cpu_we = 1'b0; cpu_din = '0;
        hs_address = '0; hs_data_in = '0; hs_write_enable = 1'b0;
        hs_read_intent = 1'b0; hs_write_intent = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_mode, guard_left;
        logic [DW-1:0] m_rd, m_cap, m_hs, nr, e_din, e_dout;
        logic [AW-1:0] e_addr;
        logic e_we, hs_side, intent, ok;

        // rint wint p hwe cwe | grant ram_we hs_side
        vecs[0]  = '{0,0,0,0,1, 0,1,0};
        vecs[1]  = '{0,1,0,1,1, 0,1,0};
        vecs[2]  = '{0,1,0,1,1, 0,0,0};
        vecs[3]  = '{0,1,0,1,1, 0,0,0};
        vecs[4]  = '{0,1,1,0,0, 0,0,0};
        vecs[5]  = '{0,1,1,1,0, 1,1,1};
        vecs[6]  = '{0,1,0,1,0, 1,0,1};
        vecs[7]  = '{0,1,0,1,1, 0,0,1};
        vecs[8]  = '{0,1,1,1,1, 0,0,1};
        vecs[9]  = '{0,1,1,0,1, 0,1,0};
        vecs[10] = '{1,0,1,0,0, 0,0,0};
        vecs[11] = '{0,0,1,1,0, 1,1,1};
        vecs[12] = '{0,0,1,1,0, 0,0,1};
        vecs[13] = '{1,0,0,0,0, 0,0,1};
        vecs[14] = '{1,0,0,0,0, 0,0,0};
        vecs[15] = '{0,0,1,0,1, 0,0,0};
        vecs[16] = '{0,0,1,0,1, 0,1,0};

        // Reset state.
        do_reset();
        #3;
        chk("rst_grant", 32'(hs_grant), 32'(0));
        chk("rst_hs_dout", 32'(hs_data_out), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(cpu_addr));

        // Vector table: hold-off, pause abort, guard, release, ARM withdraw.
        cpu_addr = 11'h055; hs_address = 11'h0AA; cpu_din = 8'h11; hs_data_in = 8'h22;
        for (int i = 0; i < 17; i++) begin
            hs_read_intent = vecs[i].rint; hs_write_intent = vecs[i].wint;
            paused = vecs[i].p; hs_write_enable = vecs[i].hwe; cpu_we = vecs[i].cwe;
            #3;
            chk($sformatf("vec%0d_grant", i), 32'(hs_grant), 32'(vecs[i].eg));
            chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].ewe));
            chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr),
                32'(vecs[i].ehs ? hs_address : cpu_addr));
            tick();
        end

        // Grant with CPU already paused, then read 0x123.
        do_reset();
        cpu_write(11'h123, 8'h5A);
        paused = 1'b1; hs_read_intent = 1'b1; hs_address = 11'h123;
        #3 chk("c0_grant", 32'(hs_grant), 32'(0));
        tick(); #3 chk("c1_grant", 32'(hs_grant), 32'(0));
        tick(); #3 chk("c2_grant", 32'(hs_grant), 32'(1));
        chk("c2_ram_addr", 32'(ram_addr), 32'(11'h123));
        tick();
        tick(); #3 chk("c4_hs_dout", 32'(hs_data_out), 32'(8'h5A));

        // Hiscore write 0xA5 to 0x7FF, then read it back.
        hs_address = 11'h7FF; hs_data_in = 8'hA5; hs_write_enable = 1'b1;
        tick(); hs_write_enable = 1'b0;
        #3 chk("hs_wr_mem", 32'(mem[11'h7FF]), 32'(8'hA5));
        tick();
        tick(); #3 chk("hs_wr_readback", 32'(hs_data_out), 32'(8'hA5));

        // Reset mid-burst.
        reset = 1'b1;
        #1;
        chk("rstmid_grant", 32'(hs_grant), 32'(0));
        chk("rstmid_hs_dout", 32'(hs_data_out), 32'(0));
        hs_read_intent = 1'b0; paused = 1'b0;
        cpu_addr = 11'h010; cpu_din = 8'h33; cpu_we = 1'b1;
        @(posedge clk_sys); #1 reset = 1'b0;
        #3;
        chk("rstmid_ram_addr", 32'(ram_addr), 32'(11'h010));
        chk("rstmid_ram_we", 32'(ram_we), 32'(1));
        tick(); cpu_we = 1'b0;
        #3 chk("cpu_wr_mem", 32'(mem[11'h010]), 32'(8'h33));
        tick(); #3 chk("cpu_rd", 32'(cpu_dout), 32'(8'h33));

        // cpu_dout holds while the hiscore side owns the port, then release timing.
        hs_read_intent = 1'b1; paused = 1'b1; cpu_addr = 11'h123; hs_address = 11'h7FF;
        tick(); #3 chk("hold_arm", 32'(cpu_dout), 32'(8'h33));
        tick(); #3 chk("hold_hs", 32'(cpu_dout), 32'(8'h33));
        chk("hold_hs_grant", 32'(hs_grant), 32'(1));
        hs_read_intent = 1'b0;
        tick(); #3 chk("rel_grant", 32'(hs_grant), 32'(0));
        tick(); #3 chk("rel_guard_addr", 32'(ram_addr), 32'(11'h7FF));
        tick(); #3 chk("rel_cpu_addr", 32'(ram_addr), 32'(11'h123));

`ifdef HS_ARB_VBLANK_ONLY_EN
        do_reset();
        vblank = 1'b0; paused = 1'b1; hs_read_intent = 1'b1; hs_address = 11'h0F0;
        tick(); tick(); tick();
        #3 chk("vb_nogrant", 32'(hs_grant), 32'(0));
        vblank = 1'b1;
        tick(); #3 chk("vb_grant", 32'(hs_grant), 32'(1));
        vblank = 1'b0;
        tick(); #3 chk("vb_exit_grant", 32'(hs_grant), 32'(0));
        chk("vb_exit_addr", 32'(ram_addr), 32'(11'h0F0));
`endif

        // Random run against an ownership model.
        do_reset();
        shadow = mem;
        m_mode = M_CPU; guard_left = 0;
        m_rd = shadow[0]; m_cap = '0; m_hs = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) hs_read_intent = ~hs_read_intent;
            if ($urandom_range(0, 8) == 0) hs_write_intent = ~hs_write_intent;
            if ($urandom_range(0, 4) == 0) paused = ~paused;
            if ($urandom_range(0, 3) == 0) vblank = ~vblank;
            hs_write_enable = 1'($urandom_range(0, 1));
            cpu_we = ($urandom_range(0, 3) == 0);
            cpu_addr = 11'($urandom_range(0, 15));
            hs_address = 11'($urandom_range(0, 15));
            cpu_din = 8'($urandom);
            hs_data_in = 8'($urandom);
            #3;
            hs_side = (m_mode == M_HS) || (m_mode == M_GRD);
            e_addr = hs_side ? hs_address : cpu_addr;
            e_din = hs_side ? hs_data_in : cpu_din;
            e_we = (m_mode == M_CPU) ? cpu_we :
                   (m_mode == M_HS) ? (hs_write_enable & paused) : 1'b0;
            e_dout = (m_mode == M_CPU) ? m_rd : m_cap;
            chk("rnd_grant", 32'(hs_grant), 32'(m_mode == M_HS));
            chk("rnd_ram_we", 32'(ram_we), 32'(e_we));
            chk("rnd_ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("rnd_ram_din", 32'(ram_din), 32'(e_din));
            chk("rnd_cpu_dout", 32'(cpu_dout), 32'(e_dout));
            chk("rnd_hs_dout", 32'(hs_data_out), 32'(m_hs));

            nr = shadow[e_addr];
            if (e_we) shadow[e_addr] = e_din;
            if (m_mode == M_HS) m_hs = m_rd;
            if (m_mode == M_CPU) m_cap = m_rd;
            m_rd = nr;

            intent = hs_read_intent | hs_write_intent;
`ifdef HS_ARB_VBLANK_ONLY_EN
            ok = paused & vblank;
`else
            ok = paused;
`endif
            if (m_mode == M_CPU) begin
                if (intent) m_mode = M_ARM;
            end else if (m_mode == M_ARM) begin
                if (!intent) m_mode = M_CPU;
                else if (ok) m_mode = M_HS;
            end else if (m_mode == M_HS) begin
                if (!intent || !ok) begin
                    m_mode = M_GRD;
                    guard_left = GUARD;
                end
            end else begin
                guard_left = guard_left - 1;
                if (guard_left == 0) m_mode = M_CPU;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
